multi_button_detector: RTL and testbench
========================================

MULTI_BUTTON_DETECTOR -- requirements
Module: multi_button_detector

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, 1..32.
REQ-002 Parameter DB_CYCLES, default 16: consecutive stable synchronised samples required to accept a level change, 1..65535.
REQ-003 Parameter REPEAT_DELAY, default 50000: held cycles after a press before the first repeat pulse, at least 1.
REQ-004 Parameter REPEAT_PERIOD, default 10000: cycles between later repeat pulses, at least 1.
REQ-005 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 btn_in  input  N_CH  raw asynchronous button levels, 1 = pressed.
REQ-008 btn_level  output  N_CH  debounced level per channel.
REQ-009 press_pulse  output  N_CH  one-cycle pulse on an accepted 0->1 change.
REQ-010 release_pulse  output  N_CH  one-cycle pulse on an accepted 1->0 change.
REQ-011 repeat_pulse  output  N_CH  one-cycle auto-repeat pulse while held.

Function
REQ-012 Each channel SHALL be fully independent; there is no shared state between channels.
REQ-013 Each btn_in bit SHALL pass a 2-flop synchroniser before any other logic.
REQ-014 Counter behaviour while the synchronised sample differs from btn_level:
- the channel counter SHALL increment each cycle;
- any cycle where they match SHALL clear the counter to 0.
REQ-015 When the counter reaches DB_CYCLES, the following SHALL happen on the same edge:
- btn_level toggles;
- the counter clears;
- press_pulse or release_pulse is registered high for exactly one cycle.
REQ-016 Latency: a clean input change first sampled at edge k SHALL update btn_level and the pulse at edge k+1+DB_CYCLES.
REQ-017 A bounce shorter than DB_CYCLES synchronised cycles SHALL produce no level change and no pulse.
REQ-018 The per-channel FSM SHALL have the states IDLE, PRESSED and REPEAT:
- IDLE->PRESSED on an accepted press;
- PRESSED->REPEAT after REPEAT_DELAY cycles held;
- PRESSED or REPEAT->IDLE on an accepted release.
REQ-019 In REPEAT, repeat_pulse SHALL fire on entry and then every REPEAT_PERIOD cycles.
REQ-020 press_pulse and repeat_pulse SHALL never be high in the same cycle for the same channel.
REQ-021 An accepted release SHALL cancel a pending repeat in the same cycle, so no repeat_pulse is issued on the release cycle.
REQ-022 Repeat counters SHALL saturate and never wrap; an input held indefinitely SHALL keep the periodic repeat cadence.

Reset
REQ-023 While rst is high, the following SHALL be cleared:
- synchroniser flops, counters and btn_level SHALL be 0;
- the FSM SHALL be in IDLE;
- all pulse outputs SHALL be 0.
REQ-024 A reset asserted mid-debounce or mid-repeat SHALL abort the operation.
REQ-025 No pulse SHALL be generated for a button already held at reset release until a full DB_CYCLES acceptance has completed.

Configuration
REQ-026 Macro BTN_AUTOREPEAT_EN SHALL control the auto-repeat feature.
- When defined: REPEAT state, repeat counters and repeat_pulse are implemented as specified above.
- When undefined: repeat_pulse is tied to 0, the FSM has only IDLE and PRESSED, and no repeat counters are synthesised.

Structure
REQ-027 Package btn_pkg SHALL hold:
- the FSM state enumeration;
- the counter-width helper (ceil log2);
- the default parameter constants.
REQ-028 Per-channel logic SHALL live in sub-module button_channel, instantiated N_CH times by a generate loop.

Verification
REQ-029 Verification parameters are N_CH=4, DB_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, with BTN_AUTOREPEAT_EN defined unless stated otherwise.
REQ-030 The bench SHALL cover these directed scenarios:
- ch0 clean rise at edge 10 -> btn_level[0] and press_pulse[0] high at edge 19, pulse one cycle only.
- ch1 toggles every 3 cycles for 40 cycles, then stays 0 -> no pulses and btn_level[1]=0 throughout.
- ch2 held 60 cycles after acceptance -> repeat_pulse[2] at 20, 25, 30 ... cycles after press; release_pulse[2] 9 cycles after the falling input; no repeat after release.
- ch0 and ch3 pressed on the same cycle -> identical, independent press_pulse timing.
- rst pulsed at counter value 5 with input still high -> no pulse, then acceptance 9 cycles after rst drops.
- BTN_AUTOREPEAT_EN undefined, ch2 held 60 cycles -> repeat_pulse stays 0.

Source files
------------

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the multi-button detector:
//   - default parameter constants
//   - per-channel FSM state enumeration
//   - cnt_width(): counter width helper (ceil log2, minimum 1 bit)
// Optional feature macro: BTN_AUTOREPEAT_EN (adds the REPEAT state).
// -----------------------------------------------------------------------------
package btn_pkg;

  localparam int DEF_N_CH          = 4;
  localparam int DEF_DB_CYCLES     = 16;
  localparam int DEF_REPEAT_DELAY  = 50000;
  localparam int DEF_REPEAT_PERIOD = 10000;

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } btn_state_e;
`else
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } btn_state_e;
`endif

  // Bits needed to hold 0 .. value-1 (at least one bit).
  function automatic int cnt_width(input int value);
    int w;
    w = 1;
    while ((w < 31) && ((1 << w) < value)) w++;
    return w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One button: 2-flop synchroniser, debounce counter, IDLE/PRESSED(/REPEAT)
// FSM and registered one-cycle pulses.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   btn_in          raw asynchronous level (1 = pressed)
//   btn_level       debounced level
//   press_pulse     one cycle on accepted 0->1
//   release_pulse   one cycle on accepted 1->0
//   repeat_pulse    auto-repeat pulse while held (0 without BTN_AUTOREPEAT_EN)
// Optional feature macro: BTN_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
module button_channel
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int             DBW     = cnt_width(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic           sync1_q, sync2_q;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  logic           accept_rise, accept_fall;
  btn_state_e     state_q, state_d;

  // Debounce: count consecutive cycles the synchronised sample disagrees
  // with the accepted level; a single agreeing cycle restarts the count.
  // The compare is against DB_CYCLES-1 because the final increment and the
  // level toggle land on the same edge.
  always_comb begin
    db_cnt_d    = '0;
    level_d     = level_q;
    accept_rise = 1'b0;
    accept_fall = 1'b0;
    if (sync2_q != level_q) begin
      if (db_cnt_q >= DB_LAST) begin
        level_d     = ~level_q;
        accept_rise = sync2_q;
        accept_fall = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPW     = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD);
  localparam logic [RPW-1:0] RD_LAST = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_PERIOD - 1);

  logic [RPW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic           repeat_q, repeat_d;

  // The repeat counter restarts on every pulse, so it is bounded by the
  // larger interval and never wraps; >= keeps it safe regardless.
  always_comb begin
    state_d   = state_q;
    press_d   = accept_rise;
    release_d = accept_fall;
    rpt_cnt_d = rpt_cnt_q;
    repeat_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rpt_cnt_d = '0;
        if (accept_rise) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (accept_fall) begin
          state_d   = ST_IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q >= RD_LAST) begin
          state_d   = ST_REPEAT;
          repeat_d  = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        // Release wins: a repeat due on the release edge is dropped.
        if (accept_fall) begin
          state_d   = ST_IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q >= RP_LAST) begin
          repeat_d  = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rpt_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  always_comb begin
    state_d   = state_q;
    press_d   = accept_rise;
    release_d = accept_fall;
    case (state_q)
      ST_IDLE:    if (accept_rise) state_d = ST_PRESSED;
      ST_PRESSED: if (accept_fall) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign repeat_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      state_q   <= state_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/multi_button_detector.sv
// -----------------------------------------------------------------------------
// multi_button_detector
// N_CH fully independent debounced button channels with press/release pulses
// and optional auto-repeat.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   btn_in          [N_CH] raw asynchronous levels (1 = pressed)
//   btn_level       [N_CH] debounced levels
//   press_pulse     [N_CH] one cycle per accepted press
//   release_pulse   [N_CH] one cycle per accepted release
//   repeat_pulse    [N_CH] auto-repeat pulses while held
// Optional feature macro: BTN_AUTOREPEAT_EN. Undefined: repeat_pulse is 0 and
// no repeat state or counters exist.
// -----------------------------------------------------------------------------
module multi_button_detector
  import btn_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  logic [N_CH-1:0] rpt_w;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
`ifdef BTN_AUTOREPEAT_EN
    button_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
`else
    button_channel #(
      .DB_CYCLES    (DB_CYCLES)
    ) u_ch (
`endif
      .clk          (clk),
      .rst          (rst),
      .btn_in       (btn_in[g]),
      .btn_level    (btn_level[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .repeat_pulse (rpt_w[g])
    );
  end

`ifdef BTN_AUTOREPEAT_EN
  assign repeat_pulse = rpt_w;
`else
  // Channels already drive 0; the repeat parameters stay on the interface so
  // both builds share one instantiation signature.
  assign repeat_pulse = rpt_w & {N_CH{(REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0)}};
`endif

endmodule

// File: tb/tb_multi_button_detector.sv
// Scoreboard bench: stimulus pushes expected pulse events (cycle, channel,
// kind) in time order; a negedge monitor pops one entry per observed pulse.
module tb_multi_button_detector;
  localparam int N_CH = 4, DB = 8, RD = 20, RP = 5;
  localparam int K_PRESS = 0, K_REL = 1, K_RPT = 2;

  typedef struct { int cyc; int ch; int kind; } ev_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] btn_in = '0;
  logic [N_CH-1:0] btn_level, press_pulse, release_pulse, repeat_pulse;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  bit  done = 1'b0;
  ev_t exp_q[$];

  multi_button_detector #(
    .N_CH(N_CH), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input int ch, input int k);
    ev_t e;
    e.cyc = c; e.ch = ch; e.kind = k;
    exp_q.push_back(e);
  endfunction

  // Returns at the negedge following posedge number n.
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!done) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (press_pulse[ch] && repeat_pulse[ch])
          chk($sformatf("press_repeat_overlap_ch%0d", ch), 1, 0);
        for (int k = 0; k < 3; k++) begin
          bit  p;
          ev_t e;
          p = (k == K_PRESS) ? press_pulse[ch] :
              (k == K_REL)   ? release_pulse[ch] : repeat_pulse[ch];
          if (p) begin
            if (exp_q.size() == 0) begin
              chk($sformatf("unexpected_pulse_ch%0d_kind%0d", ch, k), 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("pulse_cycle_ch%0d_kind%0d", ch, k), cyc, e.cyc);
              chk("pulse_channel", ch, e.ch);
              chk("pulse_kind", k, e.kind);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    wait_cyc(3);
    chk("rst_level", btn_level, 0);
    chk("rst_press", press_pulse, 0);
    chk("rst_release", release_pulse, 0);
    chk("rst_repeat", repeat_pulse, 0);
    wait_cyc(4); rst = 1'b0;

    // S1: ch0 clean rise sampled at edge 10 -> accepted at edge 19
    push(19, 0, K_PRESS);
    push(35, 0, K_REL);
    wait_cyc(9);  btn_in[0] = 1'b1;
    wait_cyc(18); chk("s1_level_pre", btn_level[0], 0);
    wait_cyc(19); chk("s1_level_post", btn_level[0], 1);
    wait_cyc(25); btn_in[0] = 1'b0;
    wait_cyc(34); chk("s1_rel_pre", btn_level[0], 1);
    wait_cyc(35); chk("s1_rel_post", btn_level[0], 0);

    // S2: ch1 bounces with 3-cycle runs for 40 cycles -> nothing accepted
    for (int i = 0; i < 40; i++) begin
      wait_cyc(50 + i);
      btn_in[1] = ((i / 3) % 2) == 0;
      chk("s2_level", btn_level[1], 0);
    end
    btn_in[1] = 1'b0;
    for (int i = 91; i <= 100; i++) begin
      wait_cyc(i);
      chk("s2_level_tail", btn_level[1], 0);
    end

    // S3: ch2 held 60 cycles after acceptance at edge 120
    push(120, 2, K_PRESS);
`ifdef BTN_AUTOREPEAT_EN
    for (int t = 140; t < 190; t += 5) push(t, 2, K_RPT);
`endif
    push(190, 2, K_REL);
    wait_cyc(110); btn_in[2] = 1'b1;
    wait_cyc(180); btn_in[2] = 1'b0;
    wait_cyc(189); chk("s3_level_held", btn_level[2], 1);
    wait_cyc(190); chk("s3_level_rel", btn_level[2], 0);

    // S4: ch0 and ch3 together
    push(210, 0, K_PRESS);
    push(210, 3, K_PRESS);
    push(225, 0, K_REL);
    push(225, 3, K_REL);
    wait_cyc(200); btn_in[0] = 1'b1; btn_in[3] = 1'b1;
    wait_cyc(210); chk("s4_levels", btn_level, 4'b1001);
    wait_cyc(215); btn_in[0] = 1'b0; btn_in[3] = 1'b0;
    wait_cyc(225); chk("s4_levels_rel", btn_level, 0);

    // S5: reset while ch1 counter is at 5; acceptance restarts from scratch
    push(259, 1, K_PRESS);
    push(275, 1, K_REL);
    wait_cyc(240); btn_in[1] = 1'b1;
    wait_cyc(247); rst = 1'b1;
    wait_cyc(248);
    chk("s5_rst_level", btn_level, 0);
    chk("s5_rst_press", press_pulse, 0);
    wait_cyc(249); rst = 1'b0;
    wait_cyc(258); chk("s5_level_pre", btn_level[1], 0);
    wait_cyc(259); chk("s5_level_post", btn_level[1], 1);
    wait_cyc(265); btn_in[1] = 1'b0;
    wait_cyc(275); chk("s5_level_rel", btn_level[1], 0);

    wait_cyc(290);
    chk("missing_pulses", exp_q.size(), 0);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
